// File: rtl/rsa_plaintext_serializer.sv
// rtl/rsa_plaintext_serializer.sv - captures RSA plaintext and streams it MSB-byte-first (optional RSA_SER_SKIP_ZERO_EN skips leading zero beats)
module rsa_plaintext_serializer #(
  parameter int DATA_W = 256,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] m_in,
  input  logic              m_valid,
  output logic              busy,
  output logic              drop,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done
);

  localparam int NBEATS = DATA_W / BYTE_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] load_shreg;
  logic [CNT_W-1:0]  load_cnt;

`ifdef RSA_SER_SKIP_ZERO_EN
  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [CNT_W-1:0] enc_k;
  logic [SH_W-1:0]  shift_amt;

  // Priority encoder: highest nonzero beat index; an all-zero message still emits one beat.
  always_comb begin
    enc_k = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (m_in[i*BYTE_W +: BYTE_W] != '0) begin
        enc_k = CNT_W'(i);
      end
    end
    shift_amt  = SH_W'(BYTE_W * (NBEATS - 1 - int'(enc_k)));
    load_shreg = m_in << shift_amt;
    load_cnt   = enc_k;
  end
`else
  // Full-length capture: every beat is sent, leading zeros included.
  always_comb begin
    load_shreg = m_in;
    load_cnt   = CNT_W'(NBEATS - 1);
  end
`endif

  // State and datapath registers; reset discards any held message.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load in IDLE, shift out one beat per transfer in SEND.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          shreg_d = load_shreg;
          cnt_d   = load_cnt;
          state_d = SEND;
        end
      end
      SEND: begin
        // A new result arriving mid-stream, even on the final transfer, is lost.
        if (m_valid) begin
          drop_d = 1'b1;
        end
        if (out_ready) begin
          shreg_d = shreg_q << BYTE_W;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_data  = (state_q == SEND) ? shreg_q[DATA_W-1 -: BYTE_W] : '0;
  assign out_last  = (state_q == SEND) && (cnt_q == '0);
  assign drop      = drop_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rsa_plaintext_serializer.sv
// tb/tb_rsa_plaintext_serializer.sv - directed self-checking bench for rsa_plaintext_serializer
module tb_rsa_plaintext_serializer;

  logic         clk;
  logic         reset;
  logic [255:0] m_in;
  logic         m_valid;
  logic         busy;
  logic         drop;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         done;

  int checks;
  int failures;

  logic [255:0] pat1;
  logic [255:0] pat2;
  logic [7:0]   prev_data;

  rsa_plaintext_serializer dut (
    .clk       (clk),
    .reset     (reset),
    .m_in      (m_in),
    .m_valid   (m_valid),
    .busy      (busy),
    .drop      (drop),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects the first beat to be presented now; checks nb beats with out_ready high, then done.
  task automatic stream(input logic [255:0] v, input int nb, input string tag);
    for (int i = 0; i < nb; i++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, v[255-8*i -: 8]);
      chk({tag, "_last"}, out_last, (i == nb - 1));
      chk({tag, "_done_low"}, done, 0);
      @(negedge clk);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    m_valid   = 1'b0;
    m_in      = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pat1[255-8*i -: 8] = 8'(i + 1);
      pat2[255-8*i -: 8] = 8'(8'h40 + i);
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);

    // m_valid together with reset: nothing captured
    m_in    = pat1;
    m_valid = 1'b1;
    @(negedge clk);
    chk("rst_mvalid_busy", busy, 0);
    m_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    chk("rst_mvalid_valid", out_valid, 0);

    // Test 1: full stream, out_ready high
    out_ready = 1'b1;
    m_valid   = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("t1_valid", out_valid, 1);
      chk("t1_busy", busy, 1);
      chk("t1_data", out_data, 8'(i + 1));
      chk("t1_last", out_last, (i == 31));
      @(negedge clk);
    end
    chk("t1_done", done, 1);
    chk("t1_busy_after", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // Test 2: out_ready toggling, last transfer on cycle 64
    out_ready = 1'b0;
    m_valid   = 1'b1;
    @(negedge clk);
    m_valid   = 1'b0;
    prev_data = 8'h00;
    for (int c = 1; c <= 64; c++) begin
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, 8'((c - 1) / 2 + 1));
      chk("t2_last", out_last, ((c - 1) / 2 == 31));
      if (c % 2 == 0) chk("t2_stable", out_data, prev_data);
      prev_data = out_data;
      out_ready = (c % 2 == 0);
      @(negedge clk);
    end
    chk("t2_done", done, 1);
    out_ready = 1'b1;
    @(negedge clk);

    // Test 3: m_valid during stream is dropped
    m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("t3_data", out_data, 8'(i + 1));
      chk("t3_drop", drop, (i == 6));
      if (i == 5) begin
        m_valid = 1'b1;
        m_in    = '1;
      end else begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t3_done", done, 1);

    // m_valid while done is high is accepted
    m_in    = pat1;
    m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    chk("b2b_drop", drop, 0);

    // Test 4: reset after beat 10
    for (int i = 0; i <= 10; i++) begin
      chk("t4_data", out_data, 8'(i + 1));
      if (i < 10) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("t4_valid", out_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_data0", out_data, 0);
    chk("t4_last", out_last, 0);
    chk("t4_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_done_later", done, 0);
    chk("t4_valid_later", out_valid, 0);
    m_in    = pat2;
    m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    stream(pat2, 32, "t4_new");
    @(negedge clk);

    // Test 5: leading zero bytes
    m_in    = 256'hABCD;
    m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
`ifdef RSA_SER_SKIP_ZERO_EN
    stream({16'hABCD, 240'h0}, 2, "t5_skip");
    @(negedge clk);

    // Test 6: all-zero message is one beat
    m_in    = '0;
    m_valid = 1'b1;
    @(negedge clk);
    m_valid = 1'b0;
    stream(256'h0, 1, "t6_zero");
`else
    stream(256'hABCD, 32, "t5_full");
`endif
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
